nanosoc_arbiter_param: RTL and testbench

Parametrised output-stage arbiter for the nanosoc AHB bus matrix: decides which of `NUM_PORTS` input stages drives a shared slave output port. Generalises the fixed 4-port, fixed-priority output arbiter to any port count, adds a selectable round-robin policy, and exposes burst-hold state. Sits between the input-stage request decode and the output-stage address/data muxes, one instance per slave port.

---
 rtl/nanosoc_arbiter_param.sv | 147 ++++++++++++++
 tb/tb_nanosoc_arbiter_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nanosoc_arbiter_param.sv
// Parametrised output-stage arbiter for one nanosoc AHB bus-matrix slave port.
// Optional early-termination hold release: define NANOSOC_ARB_EARLY_TERM_EN.
module nanosoc_arbiter_param #(
   parameter int unsigned NUM_PORTS   = 4,
   parameter int unsigned PORT_W      = 2,
   parameter int unsigned ROUND_ROBIN = 0,
   parameter int unsigned ET_LIMIT    = 2
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic [NUM_PORTS-1:0] req_port,
   input  logic                 HREADYM,
   input  logic                 HSELM,
   input  logic [1:0]           HTRANSM,
   input  logic [2:0]           HBURSTM,
   input  logic                 HMASTLOCKM,
   output logic [PORT_W-1:0]    addr_in_port,
   output logic                 no_port,
   output logic                 burst_hold
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_BUSY   = 2'b01;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;

   if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_num_ports
      $error("NUM_PORTS out of range");
   end
   if (int'(PORT_W) != $clog2(NUM_PORTS)) begin : g_bad_port_w
      $error("PORT_W must equal clog2(NUM_PORTS)");
   end
   if (ET_LIMIT < 1 || ET_LIMIT > 3) begin : g_bad_et_limit
      $error("ET_LIMIT out of range");
   end

   logic [3:0]           cnt_q, cnt_d;
   logic                 hold_q, hold_d;
   logic [PORT_W-1:0]    addr_q, addr_d;
   logic                 no_port_q, no_port_d;
   logic [NUM_PORTS-1:0] cand_c;
   logic                 found_c;
   logic                 nonseq_c;

   assign nonseq_c = HSELM && (HTRANSM == TRANS_NONSEQ);

`ifdef NANOSOC_ARB_EARLY_TERM_EN
   logic [1:0] et_q, et_d;
   logic [1:0] et_inc_c;
`endif

   // Burst beat counter and hold flag
   always_comb begin
      cnt_d  = cnt_q;
      hold_d = hold_q;
      if (!HSELM || (HTRANSM == TRANS_IDLE)) begin
         cnt_d  = 4'd0;
         hold_d = 1'b0;
      end else if (HTRANSM == TRANS_NONSEQ) begin
         case (HBURSTM)
            3'b110, 3'b111: begin cnt_d = 4'd15; hold_d = 1'b1; end
            3'b100, 3'b101: begin cnt_d = 4'd7;  hold_d = 1'b1; end
            3'b010, 3'b011: begin cnt_d = 4'd3;  hold_d = 1'b1; end
            default:        begin cnt_d = 4'd0;  hold_d = 1'b0; end
         endcase
      end else if (HTRANSM == TRANS_SEQ) begin
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) hold_d = 1'b0;
      end
`ifdef NANOSOC_ARB_EARLY_TERM_EN
      // A new NONSEQ while still holding ends the previous burst early
      et_inc_c = (et_q == 2'd3) ? 2'd3 : et_q + 2'd1;
      if (nonseq_c && hold_q && (et_inc_c == 2'(ET_LIMIT))) begin
         cnt_d  = 4'd0;
         hold_d = 1'b0;
      end
      if (!hold_d)                et_d = 2'd0;
      else if (nonseq_c && hold_q) et_d = et_inc_c;
      else                         et_d = et_q;
`endif
   end

   // Candidate vector and port selection
   always_comb begin
      addr_d    = addr_q;
      no_port_d = no_port_q;
      found_c   = 1'b0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         cand_c[i] = req_port[i] |
                     ((PORT_W'(i) == addr_q) && HSELM && (HTRANSM != TRANS_IDLE));
      end
      if (HMASTLOCKM || hold_d) begin
         no_port_d = 1'b0;
      end else begin
         if (ROUND_ROBIN != 0) begin
            // Ports above the current one first, then wrap to port 0 .. current
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
               if (!found_c && cand_c[i] && (PORT_W'(i) > addr_q)) begin
                  addr_d  = PORT_W'(i);
                  found_c = 1'b1;
               end
            end
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
               if (!found_c && cand_c[i] && (PORT_W'(i) <= addr_q)) begin
                  addr_d  = PORT_W'(i);
                  found_c = 1'b1;
               end
            end
         end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
               if (!found_c && cand_c[i]) begin
                  addr_d  = PORT_W'(i);
                  found_c = 1'b1;
               end
            end
         end
         if (found_c)     no_port_d = 1'b0;
         else if (!HSELM) no_port_d = 1'b1;
      end
   end

   // State registers; everything advances only on a completed transfer
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         cnt_q     <= 4'd0;
         hold_q    <= 1'b0;
         addr_q    <= '0;
         no_port_q <= 1'b1;
`ifdef NANOSOC_ARB_EARLY_TERM_EN
         et_q      <= 2'd0;
`endif
      end else if (HREADYM) begin
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         addr_q    <= addr_d;
         no_port_q <= no_port_d;
`ifdef NANOSOC_ARB_EARLY_TERM_EN
         et_q      <= et_d;
`endif
      end
   end

   assign addr_in_port = addr_q;
   assign no_port      = no_port_q;
   assign burst_hold   = hold_q;

endmodule

// File: tb/tb_nanosoc_arbiter_param.sv
// Bench for nanosoc_arbiter_param: 6-port fixed-priority and 5-port round-robin instances.
module tb_nanosoc_arbiter_param;

   localparam logic [1:0] T_IDLE = 2'd0;
   localparam logic [1:0] T_BUSY = 2'd1;
   localparam logic [1:0] T_NS   = 2'd2;
   localparam logic [1:0] T_SQ   = 2'd3;
   localparam logic [2:0] B_SGL  = 3'd0;
   localparam logic [2:0] B_WR4  = 3'd2;
   localparam logic [2:0] B_IN8  = 3'd5;
   localparam logic [2:0] B_IN16 = 3'd7;
`ifdef NANOSOC_ARB_EARLY_TERM_EN
   localparam bit ET_ON = 1'b1;
`else
   localparam bit ET_ON = 1'b0;
`endif

   typedef struct {
      logic       rstn;
      logic       hready;
      logic       hsel;
      logic [1:0] htrans;
      logic [2:0] hburst;
      logic       lock;
      logic [5:0] req;
      logic [2:0] e_addr;
      logic       e_np;
      logic       e_hold;
   } stim_t;

   typedef struct {
      logic [2:0] addr;
      logic       np;
      logic       hold;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstn, hready, hsel, lock;
   logic [1:0] htrans;
   logic [2:0] hburst;
   logic [5:0] req_fp;
   logic [4:0] req_rr;
   logic [2:0] fp_addr, rr_addr;
   logic       fp_np, fp_hold, rr_np, rr_hold;

   int   passed = 0;
   int   total  = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   nanosoc_arbiter_param #(.NUM_PORTS(6), .PORT_W(3), .ROUND_ROBIN(0), .ET_LIMIT(2)) u_fp (
      .HCLK(clk), .HRESETn(rstn), .req_port(req_fp), .HREADYM(hready), .HSELM(hsel),
      .HTRANSM(htrans), .HBURSTM(hburst), .HMASTLOCKM(lock),
      .addr_in_port(fp_addr), .no_port(fp_np), .burst_hold(fp_hold));

   nanosoc_arbiter_param #(.NUM_PORTS(5), .PORT_W(3), .ROUND_ROBIN(1), .ET_LIMIT(2)) u_rr (
      .HCLK(clk), .HRESETn(rstn), .req_port(req_rr), .HREADYM(hready), .HSELM(hsel),
      .HTRANSM(htrans), .HBURSTM(hburst), .HMASTLOCKM(lock),
      .addr_in_port(rr_addr), .no_port(rr_np), .burst_hold(rr_hold));

   task automatic apply(input stim_t r);
      rstn   = r.rstn;
      hready = r.hready;
      hsel   = r.hsel;
      htrans = r.htrans;
      hburst = r.hburst;
      lock   = r.lock;
      req_fp = r.req;
      req_rr = r.req[4:0];
      sb.push_back('{r.e_addr, r.e_np, r.e_hold});
   endtask

   task automatic test_reset();
      exp_t e;
      apply('{1'b0, 1'b0, 1'b0, T_IDLE, B_SGL, 1'b0, 6'h00, 3'd0, 1'b1, 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      total += 2;
      if ({fp_addr, fp_np, fp_hold} !== {e.addr, e.np, e.hold})
         $display("FAIL reset_fp: got addr=%0d no_port=%b hold=%b, expected addr=%0d no_port=%b hold=%b",
                  fp_addr, fp_np, fp_hold, e.addr, e.np, e.hold);
      else passed++;
      if ({rr_addr, rr_np, rr_hold} !== {e.addr, e.np, e.hold})
         $display("FAIL reset_rr: got addr=%0d no_port=%b hold=%b, expected addr=%0d no_port=%b hold=%b",
                  rr_addr, rr_np, rr_hold, e.addr, e.np, e.hold);
      else passed++;
   endtask

   task automatic test_fixed_priority();
      stim_t rows [10];
      exp_t  e;
      rows = '{
         '{1'b0, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b000000, 3'd0, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b101000, 3'd3, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b101010, 3'd1, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b000000, 3'd1, 1'b1, 1'b0},
         '{1'b1, 1'b0, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b000001, 3'd1, 1'b1, 1'b0},
         '{1'b1, 1'b0, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b000001, 3'd1, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_SGL, 1'b0, 6'b000000, 3'd0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_IDLE, B_SGL, 1'b0, 6'b000000, 3'd0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b000000, 3'd0, 1'b1, 1'b0}};
      foreach (rows[k]) begin
         apply(rows[k]);
         @(posedge clk); #1;
         e = sb.pop_front();
         total++;
         if ({fp_addr, fp_np, fp_hold} !== {e.addr, e.np, e.hold})
            $display("FAIL fixed_priority row %0d: got addr=%0d no_port=%b hold=%b, expected addr=%0d no_port=%b hold=%b",
                     k, fp_addr, fp_np, fp_hold, e.addr, e.np, e.hold);
         else passed++;
      end
   endtask

   task automatic test_round_robin();
      stim_t rows [9];
      exp_t  e;
      rows = '{
         '{1'b0, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b000000, 3'd0, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b000100, 3'd2, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_SGL, 1'b0, 6'b010101, 3'd4, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_SGL, 1'b0, 6'b010101, 3'd0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_SGL, 1'b0, 6'b010101, 3'd2, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_SGL, 1'b0, 6'b010101, 3'd4, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_SGL, 1'b0, 6'b000000, 3'd4, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_SGL, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b000000, 3'd0, 1'b1, 1'b0}};
      foreach (rows[k]) begin
         apply(rows[k]);
         @(posedge clk); #1;
         e = sb.pop_front();
         total++;
         if ({rr_addr, rr_np, rr_hold} !== {e.addr, e.np, e.hold})
            $display("FAIL round_robin row %0d: got addr=%0d no_port=%b hold=%b, expected addr=%0d no_port=%b hold=%b",
                     k, rr_addr, rr_np, rr_hold, e.addr, e.np, e.hold);
         else passed++;
      end
   endtask

   task automatic test_burst_hold();
      stim_t rows [13];
      exp_t  e;
      rows = '{
         '{1'b0, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b000000, 3'd0, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b001000, 3'd3, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_IN8, 1'b0, 6'b001001, 3'd3, 1'b0, 1'b1},
         '{1'b1, 1'b1, 1'b1, T_SQ,   B_IN8, 1'b0, 6'b000001, 3'd3, 1'b0, 1'b1},
         '{1'b1, 1'b1, 1'b1, T_SQ,   B_IN8, 1'b0, 6'b000001, 3'd3, 1'b0, 1'b1},
         '{1'b1, 1'b1, 1'b1, T_SQ,   B_IN8, 1'b0, 6'b000001, 3'd3, 1'b0, 1'b1},
         '{1'b1, 1'b0, 1'b1, T_SQ,   B_IN8, 1'b0, 6'b000001, 3'd3, 1'b0, 1'b1},
         '{1'b1, 1'b1, 1'b1, T_BUSY, B_IN8, 1'b0, 6'b000001, 3'd3, 1'b0, 1'b1},
         '{1'b1, 1'b1, 1'b1, T_SQ,   B_IN8, 1'b0, 6'b000001, 3'd3, 1'b0, 1'b1},
         '{1'b1, 1'b1, 1'b1, T_SQ,   B_IN8, 1'b0, 6'b000001, 3'd3, 1'b0, 1'b1},
         '{1'b1, 1'b1, 1'b1, T_SQ,   B_IN8, 1'b0, 6'b000001, 3'd3, 1'b0, 1'b1},
         '{1'b1, 1'b1, 1'b1, T_SQ,   B_IN8, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b000000, 3'd0, 1'b1, 1'b0}};
      foreach (rows[k]) begin
         apply(rows[k]);
         @(posedge clk); #1;
         e = sb.pop_front();
         total++;
         if ({fp_addr, fp_np, fp_hold} !== {e.addr, e.np, e.hold})
            $display("FAIL burst_hold row %0d: got addr=%0d no_port=%b hold=%b, expected addr=%0d no_port=%b hold=%b",
                     k, fp_addr, fp_np, fp_hold, e.addr, e.np, e.hold);
         else passed++;
      end
   endtask

   task automatic test_early_term();
      stim_t rows [10];
      exp_t  e;
      rows = '{
         '{1'b0, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b000000, 3'd0, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b000100, 3'd2, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_WR4, 1'b0, 6'b000001, 3'd2, 1'b0, 1'b1},
         '{1'b1, 1'b1, 1'b1, T_SQ,   B_WR4, 1'b0, 6'b000001, 3'd2, 1'b0, 1'b1},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_WR4, 1'b0, 6'b000001, 3'd2, 1'b0, 1'b1},
         '{1'b1, 1'b1, 1'b1, T_SQ,   B_WR4, 1'b0, 6'b000001, 3'd2, 1'b0, 1'b1},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_WR4, 1'b0, 6'b000001, ET_ON ? 3'd0 : 3'd2, 1'b0, !ET_ON},
         '{1'b1, 1'b1, 1'b1, T_SQ,   B_WR4, 1'b0, 6'b000001, ET_ON ? 3'd0 : 3'd2, 1'b0, !ET_ON},
         '{1'b1, 1'b1, 1'b1, T_SQ,   B_WR4, 1'b0, 6'b000001, ET_ON ? 3'd0 : 3'd2, 1'b0, !ET_ON},
         '{1'b1, 1'b1, 1'b1, T_SQ,   B_WR4, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0}};
      foreach (rows[k]) begin
         apply(rows[k]);
         @(posedge clk); #1;
         e = sb.pop_front();
         total++;
         if ({fp_addr, fp_np, fp_hold} !== {e.addr, e.np, e.hold})
            $display("FAIL early_term row %0d: got addr=%0d no_port=%b hold=%b, expected addr=%0d no_port=%b hold=%b",
                     k, fp_addr, fp_np, fp_hold, e.addr, e.np, e.hold);
         else passed++;
      end
   endtask

   task automatic test_lock();
      stim_t rows [8];
      exp_t  e;
      rows = '{
         '{1'b0, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b000000, 3'd0, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b0, T_IDLE, B_SGL, 1'b0, 6'b010000, 3'd4, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_SGL, 1'b1, 6'b000001, 3'd4, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b1, T_NS,   B_SGL, 1'b1, 6'b000001, 3'd4, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_SGL, 1'b1, 6'b000001, 3'd4, 1'b0, 1'b0},
         '{1'b1, 1'b0, 1'b1, T_NS,   B_SGL, 1'b1, 6'b000001, 3'd4, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_SGL, 1'b1, 6'b000001, 3'd4, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_SGL, 1'b0, 6'b000001, 3'd0, 1'b0, 1'b0}};
      foreach (rows[k]) begin
         apply(rows[k]);
         @(posedge clk); #1;
         e = sb.pop_front();
         total++;
         if ({fp_addr, fp_np, fp_hold} !== {e.addr, e.np, e.hold})
            $display("FAIL lock row %0d: got addr=%0d no_port=%b hold=%b, expected addr=%0d no_port=%b hold=%b",
                     k, fp_addr, fp_np, fp_hold, e.addr, e.np, e.hold);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_burst();
      stim_t rows [6];
      exp_t  e;
      rows = '{
         '{1'b0, 1'b1, 1'b0, T_IDLE, B_SGL,  1'b0, 6'b000000, 3'd0, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b0, T_IDLE, B_SGL,  1'b0, 6'b100000, 3'd5, 1'b0, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_NS,   B_IN16, 1'b0, 6'b000010, 3'd5, 1'b0, 1'b1},
         '{1'b1, 1'b1, 1'b1, T_SQ,   B_IN16, 1'b0, 6'b000010, 3'd5, 1'b0, 1'b1},
         '{1'b0, 1'b0, 1'b1, T_SQ,   B_IN16, 1'b0, 6'b000010, 3'd0, 1'b1, 1'b0},
         '{1'b1, 1'b1, 1'b1, T_BUSY, B_IN16, 1'b0, 6'b000010, 3'd0, 1'b0, 1'b0}};
      foreach (rows[k]) begin
         apply(rows[k]);
         @(posedge clk); #1;
         e = sb.pop_front();
         total++;
         if ({fp_addr, fp_np, fp_hold} !== {e.addr, e.np, e.hold})
            $display("FAIL reset_mid_burst row %0d: got addr=%0d no_port=%b hold=%b, expected addr=%0d no_port=%b hold=%b",
                     k, fp_addr, fp_np, fp_hold, e.addr, e.np, e.hold);
         else passed++;
      end
   endtask

   initial begin
      rstn = 1'b0; hready = 1'b0; hsel = 1'b0; lock = 1'b0;
      htrans = T_IDLE; hburst = B_SGL; req_fp = '0; req_rr = '0;
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_burst_hold();
      test_early_term();
      test_lock();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
